// File: rtl/alu_arbiter_pkg.sv
// Shared constants and types for the ALU arbiter: op-code encoding,
// requester/lock-counter sizing and the lock FSM state type.
package alu_arbiter_pkg;

  // Upper bound on requesters; index width is sized for this maximum.
  localparam int ALU_NREQ_MAX   = 4;
  localparam int ALU_LOCK_CNT_W = 4;
  localparam int ALU_IDX_W      = 2;

  // ALU op-code encoding; all eight codes are legal.
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_LSL = 3'd5,
    ALU_LSR = 3'd6,
    ALU_ASR = 3'd7
  } alu_op_e;

  // Lock FSM states; the owning requester is tracked separately.
  typedef enum logic {
    LOCK_UNLOCKED = 1'b0,
    LOCK_LOCKED   = 1'b1
  } lock_state_e;

  // Round-robin successor of idx among nreq requesters.
  function automatic logic [ALU_IDX_W-1:0] next_ptr(input logic [ALU_IDX_W-1:0] idx,
                                                    input int nreq);
    int sum;
    sum = int'(idx) + 1;
    if (sum >= nreq) begin
      sum = 0;
    end
    return ALU_IDX_W'(sum);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Rotating-priority search: grants the first set request found starting
// at ptr and moving upward with wrap-around. Purely combinational.
module rr_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]      req,
  input  logic [ALU_IDX_W-1:0] ptr,
  output logic [NREQ-1:0]      gnt
);

  // Scan NREQ positions from ptr; the first requester found wins.
  always_comb begin
    int   pos;
    logic found;
    gnt   = '0;
    found = 1'b0;
    pos   = 0;
    for (int off = 0; off < NREQ; off++) begin
      pos = int'(ptr) + off;
      if (pos >= NREQ) begin
        pos = pos - NREQ;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!found && (pos == i) && req[i]) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered 8-bit ALU among NREQ requesters. One grant per
// cycle, round-robin, with an optional bounded lock for chained ops. The
// winner's fields drive the ALU combinationally; the result returns on
// alu_out one cycle later, flagged by a registered one-hot rsp_valid.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_lock,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  input  logic [3*NREQ-1:0] req_op,
  input  logic [3*NREQ-1:0] req_shamt,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_data,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [2:0]        alu_op,
  output logic [2:0]        alu_shamt,
  input  logic [7:0]        alu_out
);

  localparam logic [ALU_LOCK_CNT_W-1:0] LOCK_MAX_C = ALU_LOCK_CNT_W'(LOCK_MAX);
  localparam logic [ALU_LOCK_CNT_W-1:0] CNT_ONE    = ALU_LOCK_CNT_W'(1);

  lock_state_e                state_q, state_d;
  logic [ALU_IDX_W-1:0]       owner_q, owner_d;
  logic [ALU_LOCK_CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [ALU_IDX_W-1:0]       ptr_q, ptr_d;
  logic [NREQ-1:0]            rsp_valid_q;

  logic [NREQ-1:0]            rr_gnt;
  logic [NREQ-1:0]            owner_onehot;
  logic                       owner_valid;
  logic                       lock_hold;
  logic [NREQ-1:0]            gnt;
  logic                       any_gnt;
  logic [ALU_IDX_W-1:0]       gnt_idx;
  logic                       gnt_lock;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (rr_gnt)
  );

  // Decode the lock owner into a one-hot and its current valid bit.
  always_comb begin
    owner_onehot = '0;
    owner_valid  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == ALU_IDX_W'(i)) begin
        owner_onehot[i] = 1'b1;
        owner_valid     = req_valid[i];
      end
    end
  end

  // A live, unexhausted lock overrides the round-robin choice.
  assign lock_hold = (state_q == LOCK_LOCKED) && owner_valid && (lock_cnt_q < LOCK_MAX_C);
  assign gnt       = lock_hold ? owner_onehot : rr_gnt;
  assign any_gnt   = |gnt;

  // Winner index, its lock request, and the ALU input mux (zero when idle).
  always_comb begin
    gnt_idx   = '0;
    gnt_lock  = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = '0;
    alu_shamt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_idx   = ALU_IDX_W'(i);
        gnt_lock  = req_lock[i];
        alu_a     = req_a[8*i +: 8];
        alu_b     = req_b[8*i +: 8];
        alu_op    = req_op[3*i +: 3];
        alu_shamt = req_shamt[3*i +: 3];
      end
    end
  end

  // Lock FSM next state: take, extend, release, drop or force-release.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      LOCK_UNLOCKED: begin
        if (any_gnt && gnt_lock) begin
          state_d    = LOCK_LOCKED;
          owner_d    = gnt_idx;
          lock_cnt_d = CNT_ONE;
        end
      end
      LOCK_LOCKED: begin
        if (lock_hold) begin
          if (gnt_lock) begin
            lock_cnt_d = lock_cnt_q + CNT_ONE;
          end else begin
            state_d    = LOCK_UNLOCKED;
            lock_cnt_d = '0;
          end
        end else begin
          // Owner went idle or exhausted its budget. A different winner may
          // take a fresh lock now; the old owner must wait for a later grant.
          state_d    = LOCK_UNLOCKED;
          lock_cnt_d = '0;
          if (any_gnt && gnt_lock && (gnt_idx != owner_q)) begin
            state_d    = LOCK_LOCKED;
            owner_d    = gnt_idx;
            lock_cnt_d = CNT_ONE;
          end
        end
      end
      default: begin
        state_d    = LOCK_UNLOCKED;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Pointer moves past every winner, locked or not; holds when idle.
  assign ptr_d = any_gnt ? next_ptr(gnt_idx, NREQ) : ptr_q;

  // Lock FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOCK_UNLOCKED;
      owner_q    <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Round-robin pointer and response flag, aligned with the ALU's latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      rsp_valid_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= gnt;
    end
  end

  // Hold off acceptance while reset is asserted.
  assign req_ready = gnt & {NREQ{rst_n}};
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = alu_out;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 8-bit registered ALU between NREQ requesters, e.g. execute stage, address generator and debug port.
- Each requester presents an operation with valid/ready. The arbiter grants one per cycle round-robin, drives the ALU operand and op inputs, and returns the result to the winner one cycle later.
- An optional lock lets a requester chain back-to-back ops. LOCK_MAX bounds the lock so no requester starves.
- Sits between the requesting stages and the alu instance; it contains no arithmetic of its own.

Parameters:
- NREQ, 2, number of requesters (2..4).
- LOCK_MAX, 4, maximum consecutive locked grants before a forced release (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  requester i has an op pending.
- req_lock  input  NREQ  requester i asks to keep the grant after this op.
- req_a  input  8*NREQ  operand a, slice [8i+7:8i].
- req_b  input  8*NREQ  operand b.
- req_op  input  3*NREQ  op code (alu.vh encoding).
- req_shamt  input  3*NREQ  shift amount.
- req_ready  output  NREQ  one-hot; op of requester i accepted this cycle.
- rsp_valid  output  NREQ  one-hot; result for requester i present this cycle.
- rsp_data  output  8  result, valid when any rsp_valid bit is set.
- alu_a  output  8  to ALU a.
- alu_b  output  8  to ALU b.
- alu_op  output  3  to ALU op.
- alu_shamt  output  3  to ALU shamt.
- alu_out  input  8  from ALU out (registered in the ALU, 1-cycle latency).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: rsp_valid=0, rr pointer=0 (requester 0 highest priority), lock_owner=none, lock_cnt=0.
- Reset values, continued: req_ready=0 during reset; alu_a/alu_b/alu_op/alu_shamt=0 while idle.
- Arbitration (combinational, cycle T): candidates are the req_valid bits.
  - If lock_owner=k and req_valid[k] and lock_cnt<LOCK_MAX, grant k.
  - Otherwise grant the first valid requester searching from rr pointer upward with wrap-around.
  - No valid requester means no grant and req_ready=0.
- Handshake: transfer when req_valid[i]&req_ready[i]. req_ready depends on req_valid, but req_valid must not depend on req_ready.
- Throughput: at most one transfer per cycle, full rate with no bubbles.
- ALU drive: alu_a/b/op/shamt is a combinational mux of the granted requester's fields in cycle T.
- Response: rsp_valid is registered as the one-hot of the grant in T and asserted in cycle T+1. rsp_data=alu_out passes through in T+1.
- No response backpressure: the requester must accept rsp in the cycle rsp_valid is asserted.
- The ALU updates out every cycle, so the arbiter keeps no result copy.
- Pointer: on a grant to i, rr pointer <= (i+1) mod NREQ. It is unchanged with no grant.
- Lock FSM, states UNLOCKED and LOCKED(k):
  - UNLOCKED -> LOCKED(k), lock_cnt=1: grant to k with req_lock[k]=1.
  - LOCKED(k), grant to k with req_lock[k]=1 and lock_cnt<LOCK_MAX: stay, lock_cnt++.
  - LOCKED(k) -> UNLOCKED: grant to k with req_lock[k]=0.
  - LOCKED(k) -> UNLOCKED: req_valid[k]=0 in any cycle. The lock drops and normal RR applies in that same cycle.
  - LOCKED(k) with lock_cnt==LOCK_MAX: k gets no priority. RR grants from the pointer, state goes to UNLOCKED, lock_cnt=0. k may re-lock on a later grant.
  - LOCK_MAX=1 makes every lock a no-op beyond a single grant.
- Simultaneous events: all requesters valid gives a strict rotating grant, each exactly once per NREQ cycles when no lock is held.
- Reset mid-operation: an in-flight rsp_valid is cleared immediately and that result is dropped. Requesters must reissue.
- No illegal-op checking: all 8 op codes are legal.

Decomposition:
- Op-code constants stay in alu.vh. Add ALU_NREQ_MAX=4 and ALU_LOCK_CNT_W=4 there.
- Sub-module rr_arbiter (NREQ; inputs req, ptr; output one-hot gnt) implements the rotating priority search.
- alu_arbiter adds the lock FSM, the muxes and the response register around rr_arbiter.

Test Plan:
- Reset, then req_valid=01, a=8'h05, b=8'h03, op=ADD -> req_ready=01 at T; rsp_valid=01, rsp_data=8'h08 at T+1.
- Both valid every cycle for 6 cycles, no lock -> grants 0,1,0,1,0,1; each rsp_data matches its own op (SUB 8'h10-8'h01=8'h0F to req1).
- Req0 lock held with LOCK_MAX=4, req1 valid throughout -> grants 0,0,0,0,1,0,... ; lock_cnt wraps to forced release.
- Req0 locked, drops req_valid for one cycle while req1 is valid -> req1 granted that cycle, lock released.
- Back-to-back LSL a=8'h81 shamt=1 then LSR a=8'h81 shamt=7 -> rsp_data 8'h02 then 8'h01 in consecutive cycles.
- Assert rst_n=0 in the cycle after a grant -> rsp_valid=0 immediately; pointer returns to 0 and the next grant goes to requester 0.
